// File: rtl/joy_quad_mux_if.sv
// joy_quad_mux_if: joystick/encoder bundle between the emu top and joy_quad_mux.
//   clkdiv         - clk_sys cycles per quadrature step, shared by all channels
//   left/right     - joystick direction per channel, active high
//   ext_a/ext_b    - physical encoder phases per channel, asynchronous
//   enc_a/enc_b    - selected quadrature phases per channel, registered
//   src_ext        - 1 = channel driven by the physical encoder
// master drives the inputs (emu top / bench); slave is joy_quad_mux.
interface joy_quad_mux_if #(
  parameter int CHANNELS = 2,
  parameter int CLKDIV_W = 16
);
  logic [CLKDIV_W-1:0] clkdiv;
  logic [CHANNELS-1:0] left;
  logic [CHANNELS-1:0] right;
  logic [CHANNELS-1:0] ext_a;
  logic [CHANNELS-1:0] ext_b;
  logic [CHANNELS-1:0] enc_a;
  logic [CHANNELS-1:0] enc_b;
  logic [CHANNELS-1:0] src_ext;

  modport master (
    output clkdiv, left, right, ext_a, ext_b,
    input  enc_a, enc_b, src_ext
  );

  modport slave (
    input  clkdiv, left, right, ext_a, ext_b,
    output enc_a, enc_b, src_ext
  );
endinterface

// File: rtl/joy_quad_mux.sv
// joy_quad_mux: per-channel joystick-to-quadrature converter with arbitration
// against a physical encoder on user-port pins.
//   clk_sys  - system clock
//   reset    - asynchronous active-high reset (released synchronously inside)
//   bus      - joy_quad_mux_if.slave (clkdiv, left, right, ext_a/b in;
//              enc_a/b, src_ext out)
// Optional: define JOY_QUAD_ACCEL_EN to shorten the step period after
// ACCEL_STEPS (then 2*ACCEL_STEPS) consecutive same-direction steps.

// joy_quad_lane: one spinner channel.
//   clk_i, rst_i        - clock, async active-high reset
//   clkdiv_i            - shared step divisor
//   left_i, right_i     - joystick direction
//   ext_a_i, ext_b_i    - async encoder phases
//   enc_a_o, enc_b_o    - registered selected phases
//   src_ext_o           - encoder currently owns the outputs
module joy_quad_lane #(
  parameter int CLKDIV_W    = 16,
  parameter int ACCEL_STEPS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CLKDIV_W-1:0] clkdiv_i,
  input  logic                left_i,
  input  logic                right_i,
  input  logic                ext_a_i,
  input  logic                ext_b_i,
  output logic                enc_a_o,
  output logic                enc_b_o,
  output logic                src_ext_o
);
  localparam logic [CLKDIV_W-1:0] ONE = CLKDIV_W'(1);

  // {A,B} pairs throughout
  logic [1:0]          sync1_q, sync2_q, prev_q;
  logic [1:0]          ph_q, ph_d;
  logic [1:0]          enc_q, enc_d;
  logic [CLKDIV_W-1:0] cnt_q, cnt_d, cnt_eff, div_eff;
  logic                dir_q, dir_d, act_q, act_d, src_q, src_d;
  logic                fwd, bwd, active, rev, tick, ext_chg;

  assign fwd     = right_i & ~left_i;
  assign bwd     = left_i & ~right_i;
  assign active  = fwd | bwd;
  // Direct fwd<->bwd switch without an idle cycle in between.
  assign rev     = active & act_q & (fwd != dir_q);
  assign ext_chg = (sync2_q != prev_q);

  // A reversal behaves like a fresh press: count from zero this cycle.
  assign cnt_eff = rev ? '0 : cnt_q;
  // >= rather than == so a clkdiv drop below the running count ticks at once.
  assign tick    = active & (cnt_eff >= div_eff - ONE);

`ifdef JOY_QUAD_ACCEL_EN
  localparam int STP_MAX = 2 * ACCEL_STEPS;
  localparam int STP_W   = $clog2(STP_MAX + 1);
  localparam logic [STP_W-1:0] STP_HALF = STP_W'(ACCEL_STEPS);
  localparam logic [STP_W-1:0] STP_FULL = STP_W'(STP_MAX);

  logic [STP_W-1:0]    stp_q, stp_d, stp_eff;
  logic [CLKDIV_W-1:0] div_sh;

  assign stp_eff = rev ? '0 : stp_q;

  always_comb begin
    div_sh = clkdiv_i;
    if (stp_eff >= STP_FULL)      div_sh = clkdiv_i >> 2;
    else if (stp_eff >= STP_HALF) div_sh = clkdiv_i >> 1;
    div_eff = (div_sh == '0) ? ONE : div_sh;
  end

  always_comb begin
    stp_d = stp_eff;
    if (!active)                        stp_d = '0;
    else if (tick && stp_eff != STP_FULL) stp_d = stp_eff + STP_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stp_q <= '0;
    else       stp_q <= stp_d;
  end
`else
  logic unused_accel;
  assign unused_accel = (ACCEL_STEPS != 0);
  assign div_eff = (clkdiv_i == '0) ? ONE : clkdiv_i;
`endif

  always_comb begin
    cnt_d = cnt_eff + ONE;
    ph_d  = ph_q;
    src_d = src_q;
    if (!active || tick) cnt_d = '0;
    // Gray walk: fwd 00->01->11->10, bwd the reverse.
    if (tick) ph_d = fwd ? {ph_q[0], ~ph_q[1]} : {~ph_q[0], ph_q[1]};
    // Emulated tick beats an encoder edge in the same cycle.
    if (tick)         src_d = 1'b0;
    else if (ext_chg) src_d = 1'b1;
    enc_d = src_d ? sync2_q : ph_d;
    dir_d = active ? fwd : dir_q;
    act_d = active;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ph_q    <= '0;
      enc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      act_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      sync1_q <= {ext_a_i, ext_b_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ph_q    <= ph_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      act_q   <= act_d;
      src_q   <= src_d;
    end
  end

  assign enc_a_o   = enc_q[1];
  assign enc_b_o   = enc_q[0];
  assign src_ext_o = src_q;
endmodule

module joy_quad_mux #(
  parameter int CHANNELS    = 2,
  parameter int CLKDIV_W    = 16,
  parameter int ACCEL_STEPS = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  joy_quad_mux_if.slave bus
);
  logic [1:0]          rst_sync_q;
  logic                rst_int;
  logic [CHANNELS-1:0] enc_a, enc_b, src_ext;

  // Assert immediately, release two clk_sys edges after reset drops.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    joy_quad_lane #(
      .CLKDIV_W    (CLKDIV_W),
      .ACCEL_STEPS (ACCEL_STEPS)
    ) u_lane (
      .clk_i     (clk_sys),
      .rst_i     (rst_int),
      .clkdiv_i  (bus.clkdiv),
      .left_i    (bus.left[g]),
      .right_i   (bus.right[g]),
      .ext_a_i   (bus.ext_a[g]),
      .ext_b_i   (bus.ext_b[g]),
      .enc_a_o   (enc_a[g]),
      .enc_b_o   (enc_b[g]),
      .src_ext_o (src_ext[g])
    );
  end

  assign bus.enc_a   = enc_a;
  assign bus.enc_b   = enc_b;
  assign bus.src_ext = src_ext;
endmodule

// File: tb/tb_joy_quad_mux.sv
// Directed bench for joy_quad_mux (2 channels, ACCEL_STEPS=2).
module tb_joy_quad_mux;
  logic clk_sys = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] ph;

`ifdef JOY_QUAD_ACCEL_EN
  int iv[6] = '{8, 8, 4, 4, 2, 2};
`else
  int iv[6] = '{8, 8, 8, 8, 8, 8};
`endif

  joy_quad_mux_if #(.CHANNELS(2), .CLKDIV_W(16)) bus ();

  joy_quad_mux #(.CHANNELS(2), .CLKDIV_W(16), .ACCEL_STEPS(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc0();
    return {bus.enc_a[0], bus.enc_b[0]};
  endfunction

  function automatic logic [1:0] enc1();
    return {bus.enc_a[1], bus.enc_b[1]};
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.clkdiv = 16'd4;
    bus.left  = '0;
    bus.right = '0;
    bus.ext_a = '0;
    bus.ext_b = '0;
    #2;
    chk("rst_enc_a", 8'(bus.enc_a), 8'h0);
    chk("rst_enc_b", 8'(bus.enc_b), 8'h0);
    chk("rst_src",   8'(bus.src_ext), 8'h0);
    step(2);
    reset = 1'b0;
    step(4);
    chk("post_rst_enc0", 8'(enc0()), 8'h0);

    // forward, clkdiv=4
    bus.right[0] = 1'b1;
    step(3); chk("fwd_early", 8'(enc0()), 8'h0);
    step(1); chk("fwd_01", 8'(enc0()), 8'h1);
    chk("fwd_ch1_idle", 8'(enc1()), 8'h0);
    chk("fwd_src", 8'(bus.src_ext), 8'h0);
    step(3); chk("fwd_hold", 8'(enc0()), 8'h1);
    step(1); chk("fwd_11", 8'(enc0()), 8'h3);
    step(4); chk("fwd_10", 8'(enc0()), 8'h2);
    step(4); chk("fwd_00", 8'(enc0()), 8'h0);
    step(4); chk("fwd_01b", 8'(enc0()), 8'h1);
    step(4); chk("fwd_11b", 8'(enc0()), 8'h3);
    bus.right[0] = 1'b0;
    step(6); chk("idle_hold", 8'(enc0()), 8'h3);

    // backward from 11
    bus.left[0] = 1'b1;
    step(3); chk("bwd_early", 8'(enc0()), 8'h3);
    step(1); chk("bwd_01", 8'(enc0()), 8'h1);
    step(4); chk("bwd_00", 8'(enc0()), 8'h0);
    bus.right[0] = 1'b1;
    step(6); chk("both_frozen", 8'(enc0()), 8'h0);
    bus.left[0] = 1'b0;
    step(3); chk("both_cnt_early", 8'(enc0()), 8'h0);
    step(1); chk("both_cnt_cleared", 8'(enc0()), 8'h1);
    bus.right[0] = 1'b0;

    // ch1 to phase 11 at clkdiv=2
    bus.clkdiv = 16'd2;
    bus.right[1] = 1'b1;
    step(2); chk("ch1_01", 8'(enc1()), 8'h1);
    step(2); chk("ch1_11", 8'(enc1()), 8'h3);
    bus.right[1] = 1'b0;
    step(2); chk("ch1_hold", 8'(enc1()), 8'h3);
    chk("ch0_indep", 8'(enc0()), 8'h1);

    // encoder takes ch1
    bus.ext_b[1] = 1'b1;
    step(2); chk("ext_lat_src", 8'(bus.src_ext[1]), 8'h0);
    chk("ext_lat_enc", 8'(enc1()), 8'h3);
    step(1); chk("ext_src", 8'(bus.src_ext[1]), 8'h1);
    chk("ext_enc", 8'(enc1()), 8'h1);
    chk("ext_ch0_src", 8'(bus.src_ext[0]), 8'h0);
    bus.right[1] = 1'b1;
    step(1); chk("ext_keep_src", 8'(bus.src_ext[1]), 8'h1);
    step(1); chk("emu_back_src", 8'(bus.src_ext[1]), 8'h0);
    chk("emu_back_enc", 8'(enc1()), 8'h2);
    bus.right[1] = 1'b0;

    // tick and ext edge on the same cycle, ch0 at 01
    bus.clkdiv = 16'd4;
    bus.right[0] = 1'b1;
    step(1);
    bus.ext_a[0] = 1'b1;
    step(2); chk("tie_pre", 8'(enc0()), 8'h1);
    step(1); chk("tie_src", 8'(bus.src_ext[0]), 8'h0);
    chk("tie_enc", 8'(enc0()), 8'h3);
    step(2); chk("tie_after", 8'(bus.src_ext[0]), 8'h0);
    bus.right[0] = 1'b0;
    bus.ext_a[0] = 1'b0;
    step(2); chk("ext0_lat", 8'(bus.src_ext[0]), 8'h0);
    step(1); chk("ext0_src", 8'(bus.src_ext[0]), 8'h1);
    chk("ext0_enc", 8'(enc0()), 8'h0);

    // clkdiv=0 acts as 1; ch0 emulated phase is 11
    bus.clkdiv = 16'd0;
    bus.right[0] = 1'b1;
    step(1); chk("div0_src", 8'(bus.src_ext[0]), 8'h0);
    chk("div0_10", 8'(enc0()), 8'h2);
    step(1); chk("div0_00", 8'(enc0()), 8'h0);
    step(1); chk("div0_01", 8'(enc0()), 8'h1);
    step(1); chk("div0_11", 8'(enc0()), 8'h3);
    bus.clkdiv = 16'd100;
    step(50); chk("div100_hold", 8'(enc0()), 8'h3);
    bus.clkdiv = 16'd3;
    step(1); chk("div_drop_step", 8'(enc0()), 8'h2);
    step(2); chk("div3_hold", 8'(enc0()), 8'h2);
    step(1); chk("div3_step", 8'(enc0()), 8'h0);

    // step intervals at clkdiv=8
    bus.right[0] = 1'b0;
    bus.clkdiv = 16'd8;
    step(1);
    bus.right[0] = 1'b1;
    ph = 2'b00;
    for (int k = 0; k < 6; k++) begin
      step(iv[k] - 1); chk($sformatf("iv%0d_hold", k), 8'(enc0()), 8'(ph));
      ph = nxt(ph);
      step(1); chk($sformatf("iv%0d_step", k), 8'(enc0()), 8'(ph));
    end
    bus.right[0] = 1'b0;
    step(1);
    bus.right[0] = 1'b1;
    step(7); chk("repress_hold", 8'(enc0()), 8'(ph));
    ph = nxt(ph);
    step(1); chk("repress_step", 8'(enc0()), 8'(ph));

    // reset mid-count with ch1 on encoder at 11
    step(3);
    bus.ext_a[1] = 1'b1;
    step(3); chk("pre_rst_src1", 8'(bus.src_ext[1]), 8'h1);
    chk("pre_rst_enc1", 8'(enc1()), 8'h3);
    reset = 1'b1;
    #2;
    chk("async_rst_enc_a", 8'(bus.enc_a), 8'h0);
    chk("async_rst_enc_b", 8'(bus.enc_b), 8'h0);
    chk("async_rst_src",   8'(bus.src_ext), 8'h0);
    step(1);
    reset = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/joy_quad_mux.md
Name: joy_quad_mux

Overview:
- Multi-channel successor to the single-channel joystick-to-quadrature converter and its ad-hoc encoder/joystick source select.
- For each of CHANNELS spinner inputs, converts digital left/right into a quadrature A/B stream at a programmable step rate.
- Arbitrates per channel between that emulated stream and a physical encoder on user-port pins; the active source drives the core's Enc_A/Enc_B.
- Sits in the emu top between hps_io/USER_IN and the game core, on clk_sys.

Parameters:
- CHANNELS, 2, number of independent spinner channels (1..8).
- CLKDIV_W, 16, width of step-rate divisor input.
- ACCEL_STEPS, 16, consecutive same-direction steps per acceleration stage (used only with JOY_QUAD_ACCEL_EN).

Ports:
- clk_sys  in  1  system clock (12 MHz in current cores).
- reset  in  1  asynchronous, active-high reset.
- clkdiv  in  CLKDIV_W  clk_sys cycles per quadrature step, shared by all channels; 0 treated as 1.
- left  in  CHANNELS  joystick left, active high; bit i = channel i.
- right  in  CHANNELS  joystick right, active high.
- ext_a  in  CHANNELS  physical encoder phase A, asynchronous.
- ext_b  in  CHANNELS  physical encoder phase B, asynchronous.
- enc_a  out  CHANNELS  selected quadrature phase A, registered.
- enc_b  out  CHANNELS  selected quadrature phase B, registered.
- src_ext  out  CHANNELS  1 = channel i currently driven by the physical encoder.

Behaviour:
- Reset (async assert, sync release): all divider counters 0, emulated phase {A,B}=00, src_ext=0, enc_a=enc_b=0, sync flops 0.
- Direction per channel: right&~left = forward; left&~right = backward; both or neither = idle.
- Divider: counter runs only when not idle. Tick when counter == div_eff-1, then counter returns to 0. On idle, or on direction reversal, counter clears to 0.
- First step therefore occurs div_eff cycles after the press; held direction gives one step per div_eff cycles.
- Phase sequence: forward 00→01→11→10→00; backward is the reverse. Phase holds when idle; it is not reset by release.
- div_eff = max(clkdiv,1) without acceleration.
- ext_a/ext_b pass through a 2-flop synchronizer per bit. ext_chg = synced pair differs from its previous synced value.
- Arbitration, evaluated every cycle:
  - emulated tick → src_ext=0;
  - else ext_chg → src_ext=1;
  - else hold.
  - Emulated tick wins on a simultaneous event.
- Output register: enc = next src_ext ? synced ext : next emulated phase.
- Latency:
  - emulated step appears on enc one cycle after its tick cycle;
  - ext pin change appears on enc on the 3rd clk_sys edge after the change (2 sync + 1 output).
- Channels fully independent; no cross-channel interaction except the shared clkdiv.
- clkdiv change mid-count: takes effect immediately. If counter ≥ new div_eff-1, tick next cycle, then wrap.
- Reset mid-step: all state returns to reset values regardless of divider state.

Optional Feature:
- Macro JOY_QUAD_ACCEL_EN.
- Defined:
  - per-channel step counter, saturating at 2*ACCEL_STEPS, counts consecutive ticks in the same direction;
  - div_eff = clkdiv until ACCEL_STEPS ticks, then clkdiv>>1, from 2*ACCEL_STEPS on clkdiv>>2, floored at 1;
  - step counter clears on idle, reversal or reset.
- Not defined: no step counter logic, div_eff = max(clkdiv,1) always; ACCEL_STEPS ignored.

Test Plan:
- Reset then right[0]=1, clkdiv=4 → enc{a,b}[0] goes 01 at cycle 5, 11 at 9, 10 at 13, 00 at 17; channel 1 stays 00, src_ext=00.
- Phase 11 on ch0, then left[0]=1, clkdiv=4 → 01 then 00 at 4-cycle spacing. left=right=1 → phase frozen, counter 0.
- Toggle ext_a[1] with no joystick input → src_ext[1]=1 and enc_a[1] follows on the 3rd edge. Then right[1]=1, clkdiv=2 → src_ext[1]=0 at the first tick, enc[1] resumes the emulated phase (not reset to 00).
- Same-cycle emulated tick and ext_chg on ch0 → src_ext[0]=0, enc shows emulated phase.
- clkdiv=0 with right held → one step every cycle (00,01,11,10,00…). clkdiv changed 100→3 while counter=50 → step next cycle, then every 3 cycles.
- With JOY_QUAD_ACCEL_EN, ACCEL_STEPS=2, clkdiv=8, right held → step intervals 8,8,4,4,2,2,… Release one cycle, press again → back to 8. Without the macro → constant 8.
- Assert reset mid-count at phase 11, src_ext=1 → all outputs 0 immediately (async).
